// File: rtl/la_iopoc_pkg.sv
// Shared definitions for the IO-ring power-on-control sequencer:
// FSM state encoding and the fault-segment index width helper.
package la_iopoc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_UP_SETTLE = 3'd1,
        ST_UP_CHK    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_ON        = 3'd4,
        ST_DOWN      = 3'd5,
        ST_FAULT     = 3'd6
    } state_t;

    // Width of a segment index; never below one bit so N=1 still has a port.
    function automatic int fseg_width(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/la_iopoc_timer.sv
// Loadable CW-bit down-counter with a zero flag; used for settle, timeout
// and power-down spacing in the sequencer.
module la_iopoc_timer #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          dec,
    input  logic [CW-1:0] din,
    output logic          zero
);

    logic [CW-1:0] cnt_r;

    // Counter register: load wins over decrement, and it saturates at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {CW{1'b0}};
        end else if (load) begin
            cnt_r <= din;
        end else if (dec && (cnt_r != {CW{1'b0}})) begin
            cnt_r <= cnt_r - CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == {CW{1'b0}});

endmodule

// File: rtl/la_iopocseq.sv
// IO-ring power sequencer: enables N power segments in order with settle and
// power-good checks, releases IO hold when fully on, and powers down in reverse.
module la_iopocseq
    import la_iopoc_pkg::*;
#(
    parameter string TYPE = "DEFAULT",
    parameter int    N    = 4,
    parameter int    CW   = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      stop,
    input  logic [CW-1:0]             dly,
    input  logic [CW-1:0]             tmo,
    input  logic [N-1:0]              pgood,
    output logic [N-1:0]              seg_en,
    output logic                      hold,
    output logic                      ready,
    output logic                      busy,
    output logic                      fault,
    output logic [fseg_width(N)-1:0]  fault_seg
);

    localparam int            IW   = fseg_width(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    state_t        state_r, nxt_state_s;
    logic [IW-1:0] idx_r, nxt_idx_s;
    logic [N-1:0]  seg_en_r, nxt_seg_en_s;
    logic          fault_r, nxt_fault_s;
    logic [IW-1:0] fault_seg_r, nxt_fault_seg_s;
    logic          hold_r, ready_r, busy_r, nxt_busy_s;
    logic          ld_s, dec_s, zero_s;
    logic [CW-1:0] ld_val_s;
    logic [N-1:0]  bad_s;

    // Lowest index with a set bit; caller guarantees at least one is set.
    function automatic logic [IW-1:0] low_idx(input logic [N-1:0] v);
        logic [IW-1:0] r;
        r = {IW{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = IW'(i);
            end
        end
        return r;
    endfunction

    la_iopoc_timer #(.CW(CW)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (ld_s),
        .dec   (dec_s),
        .din   (ld_val_s),
        .zero  (zero_s)
    );

    // Next-state logic; stop aborts sequencing, brownout in ON outranks stop.
    always_comb begin
        nxt_state_s     = state_r;
        nxt_idx_s       = idx_r;
        nxt_seg_en_s    = seg_en_r;
        nxt_fault_s     = fault_r;
        nxt_fault_seg_s = fault_seg_r;
        ld_s            = 1'b0;
        dec_s           = 1'b0;
        ld_val_s        = dly;
        bad_s           = seg_en_r & ~pgood;
        case (state_r)
            ST_IDLE: begin
                if (stop) begin
                    nxt_state_s = ST_IDLE;
                end else if (start) begin
                    nxt_idx_s    = {IW{1'b0}};
                    nxt_seg_en_s = N'(1);
                    ld_s         = 1'b1;
                    nxt_state_s  = ST_UP_SETTLE;
                end else begin
                    nxt_state_s = ST_IDLE;
                end
            end
            ST_UP_SETTLE: begin
                if (stop) begin
                    ld_s        = 1'b1;
                    nxt_state_s = ST_DOWN;
                end else if (zero_s) begin
                    ld_s        = 1'b1;
                    ld_val_s    = tmo;
                    nxt_state_s = ST_UP_CHK;
                end else begin
                    dec_s = 1'b1;
                end
            end
            ST_UP_CHK: begin
                if (stop) begin
                    ld_s        = 1'b1;
                    nxt_state_s = ST_DOWN;
                end else if (pgood[idx_r]) begin
                    ld_s = 1'b1;
                    if (idx_r == LAST) begin
                        nxt_state_s = ST_RELEASE;
                    end else begin
                        nxt_idx_s    = idx_r + IW'(1);
                        nxt_seg_en_s = seg_en_r | (N'(1) << nxt_idx_s);
                        nxt_state_s  = ST_UP_SETTLE;
                    end
                end else if (zero_s) begin
                    nxt_seg_en_s    = {N{1'b0}};
                    nxt_fault_s     = 1'b1;
                    nxt_fault_seg_s = idx_r;
                    nxt_state_s     = ST_FAULT;
                end else begin
                    dec_s = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (stop) begin
                    ld_s        = 1'b1;
                    nxt_state_s = ST_DOWN;
                end else if (zero_s) begin
                    nxt_state_s = ST_ON;
                end else begin
                    dec_s = 1'b1;
                end
            end
            ST_ON: begin
                if (bad_s != {N{1'b0}}) begin
                    nxt_seg_en_s    = {N{1'b0}};
                    nxt_fault_s     = 1'b1;
                    nxt_fault_seg_s = low_idx(bad_s);
                    nxt_state_s     = ST_FAULT;
                end else if (stop) begin
                    nxt_idx_s   = LAST;
                    ld_s        = 1'b1;
                    nxt_state_s = ST_DOWN;
                end else begin
                    nxt_state_s = ST_ON;
                end
            end
            ST_DOWN: begin
                if (zero_s) begin
                    nxt_seg_en_s[idx_r] = 1'b0;
                    if (idx_r == {IW{1'b0}}) begin
                        nxt_state_s = ST_IDLE;
                    end else begin
                        nxt_idx_s = idx_r - IW'(1);
                        ld_s      = 1'b1;
                    end
                end else begin
                    dec_s = 1'b1;
                end
            end
            ST_FAULT: begin
                if (stop) begin
                    nxt_fault_s     = 1'b0;
                    nxt_fault_seg_s = {IW{1'b0}};
                    nxt_idx_s       = {IW{1'b0}};
                    nxt_state_s     = ST_IDLE;
                end else begin
                    nxt_state_s = ST_FAULT;
                end
            end
            default: begin
                nxt_seg_en_s    = {N{1'b0}};
                nxt_fault_s     = 1'b0;
                nxt_fault_seg_s = {IW{1'b0}};
                nxt_idx_s       = {IW{1'b0}};
                nxt_state_s     = ST_IDLE;
            end
        endcase
        nxt_busy_s = (nxt_state_s == ST_UP_SETTLE) || (nxt_state_s == ST_UP_CHK) ||
                     (nxt_state_s == ST_RELEASE)   || (nxt_state_s == ST_DOWN);
    end

    // State and registered outputs; hold/ready/busy are decoded from next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            idx_r       <= {IW{1'b0}};
            seg_en_r    <= {N{1'b0}};
            fault_r     <= 1'b0;
            fault_seg_r <= {IW{1'b0}};
            hold_r      <= 1'b1;
            ready_r     <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= nxt_state_s;
            idx_r       <= nxt_idx_s;
            seg_en_r    <= nxt_seg_en_s;
            fault_r     <= nxt_fault_s;
            fault_seg_r <= nxt_fault_seg_s;
            hold_r      <= (nxt_state_s != ST_ON);
            ready_r     <= (nxt_state_s == ST_ON);
            busy_r      <= nxt_busy_s;
        end
    end

    assign seg_en    = seg_en_r;
    assign hold      = hold_r;
    assign ready     = ready_r;
    assign busy      = busy_r;
    assign fault     = fault_r;
    assign fault_seg = fault_seg_r;

endmodule

// File: doc/la_iopocseq.md
LA_IOPOCSEQ -- requirements
Module: la_iopocseq

Interface
REQ-001 SHALL have parameter TYPE, default "DEFAULT": cell/implementation type selector, passed through only.
REQ-002 SHALL have parameter N, default 4: number of IO-ring power segments, 1..16.
REQ-003 SHALL have parameter CW, default 8: settle/timeout counter width.
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk, input, 1: the single clock.
REQ-006 SHALL have port reset, input, 1: synchronous active-high reset.
REQ-007 SHALL have port start, input, 1: request power-up; sampled only in IDLE.
REQ-008 SHALL have port stop, input, 1: request power-down or abort, or clear a fault.
REQ-009 SHALL have port dly, input, CW: settle cycles per step, loaded at step entry.
REQ-010 SHALL have port tmo, input, CW: power-good timeout cycles, loaded at check entry.
REQ-011 SHALL have port pgood, input, N: per-segment power-good, already synchronised upstream.
REQ-012 SHALL have port seg_en, output, N: per-segment power-on-control enable.
REQ-013 SHALL have port hold, output, 1: IO hold/isolation; high unless the ring is fully on.
REQ-014 SHALL have port ready, output, 1: ring fully powered.
REQ-015 SHALL have port busy, output, 1: high while sequencing.
REQ-016 SHALL have port fault, output, 1: sticky fault flag.
REQ-017 SHALL have port fault_seg, output, max(1,clog2(N)): index of the failing segment.

Function
REQ-018 SHALL implement the states IDLE, UP_SETTLE, UP_CHK, RELEASE, ON, DOWN and FAULT; busy SHALL be high in UP_SETTLE, UP_CHK, RELEASE and DOWN.
REQ-019 SHALL, in IDLE with start=1, set idx=0, set seg_en[0], load cnt=dly and enter UP_SETTLE, all on the same edge.
REQ-020 SHALL, in UP_SETTLE, decrement cnt each cycle; when cnt==0, load cnt=tmo and enter UP_CHK, giving a settle time of dly+1 cycles.
REQ-021 SHALL, in UP_CHK with pgood[idx]=1 and idx<N-1, increment idx, set the next seg_en bit, load cnt=dly and enter UP_SETTLE.
REQ-022 SHALL, in UP_CHK with pgood[idx]=1 and idx==N-1, load cnt=dly and enter RELEASE.
REQ-023 SHALL, in UP_CHK with pgood[idx]=0 and cnt==0, enter FAULT with fault_seg=idx; otherwise SHALL decrement cnt.
REQ-024 SHALL, in RELEASE when cnt==0, enter ON with hold=0 and ready=1 on the same edge.
REQ-025 SHALL, in ON when any enabled segment has pgood=0, enter FAULT with fault_seg set to the lowest such index.
REQ-026 SHALL, on entering FAULT, clear all seg_en bits, set hold=1, ready=0 and fault=1 on the same edge.
REQ-027 SHALL, in ON with stop=1, set hold=1, ready=0, idx=N-1 and cnt=dly, and enter DOWN.
REQ-028 SHALL, in DOWN when cnt==0, clear seg_en[idx]; then enter IDLE if idx==0, else decrement idx and reload cnt=dly. Segments SHALL drop in reverse order, dly+1 cycles apart.
REQ-029 SHALL, on stop in UP_SETTLE, UP_CHK or RELEASE, abort to DOWN at the current idx with cnt=dly and hold kept at 1.
REQ-030 SHALL, on stop in FAULT, clear fault and fault_seg and enter IDLE; start SHALL be ignored in FAULT.
REQ-031 SHALL give stop priority when start and stop are asserted together; start outside IDLE SHALL be ignored.
REQ-032 SHALL not let changes on dly or tmo affect a count already in progress.
REQ-033 SHALL, with N=1, go from UP_CHK directly to RELEASE and from DOWN directly to IDLE.

Reset
REQ-034 SHALL, on reset=1 at a clock edge, from any state, force IDLE, seg_en=0, hold=1, ready=0, busy=0, fault=0, fault_seg=0, idx=0 and cnt=0.
REQ-035 SHALL give reset priority over all other inputs.

Structure
REQ-036 SHALL place the state encoding typedef and the fault_seg width function in the shared package la_iopoc_pkg.
REQ-037 SHALL implement cnt as the sub-module la_iopoc_timer: a CW-bit loadable down-counter with a zero flag.

Verification (N=4, dly=3, tmo=5, pgood follows seg_en 2 cycles later)
REQ-038 SHALL cover nominal power-up: start pulse -> seg_en bits set 5 cycles apart (0x1, 0x3, 0x7, 0xF), then hold=0 and ready=1 exactly 24 cycles after seg_en[0] rises.
REQ-039 SHALL cover timeout: pgood[2] held at 0 -> FAULT 6 cycles after UP_CHK entry on segment 2, with seg_en=0, hold=1, fault=1, fault_seg=2.
REQ-040 SHALL cover power-down: stop in ON -> hold=1 and ready=0 next edge, seg_en going 0x7, 0x3, 0x1, 0x0 at 4-cycle spacing, then IDLE with busy=0.
REQ-041 SHALL cover brownout: pgood[1] drops in ON -> FAULT next edge with fault_seg=1; a subsequent stop -> IDLE with fault=0.
REQ-042 SHALL cover abort: start and stop together in IDLE -> stays IDLE; stop while settling segment 1 -> seg_en 0x3, 0x1, 0x0.
REQ-043 SHALL cover reset mid-operation: reset during UP_CHK -> all reset values after one edge.
